xbee_uart_tx: RTL
=================

# xbee_uart_tx

UART transmit stage for the XBee link: accepts bytes from the host-side logic through a valid/ready handshake, buffers them in a small FIFO, and serialises each as an 8N1 frame on the Tx line. Sits directly downstream of the baud tick generator and consumes its one-cycle `TickTack` pulse (one per bit period, 9600 bps from 100 MHz) as the sole bit-timing reference. The block has no internal baud counter.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `STOP_BITS`, default 1: stop bits per frame (1 or 2).
- `FIFO_DEPTH`, default 4: byte buffer depth; must be a power of 2, ≥2.
- `Clk` input 1: system clock, 100 MHz.
- `Reset_n` input 1: asynchronous reset, active-low.
- `TickTack` input 1: baud tick, one-`Clk`-wide pulse per bit period.
- `Data_In` input DATA_BITS: byte to transmit.
- `Data_Valid` input 1: `Data_In` is valid this cycle.
- `Data_Ready` output 1: FIFO can accept a byte. Equal to `!full`. Reset value 1.
- `Tx` output 1: serial line, registered, idle high. Reset value 1.
- `Busy` output 1: high while a frame is on the line (states other than IDLE). Reset value 0.
- `Fifo_Count` output $clog2(FIFO_DEPTH)+1: bytes currently buffered. Reset value 0.

## Operation
- Push: a byte is written when `Data_Valid && Data_Ready` on a rising `Clk` edge. A byte written in cycle k is visible to the pop logic from cycle k+1.
- FSM states:
  - IDLE: `Tx`=1.
  - START: `Tx`=0.
  - DATA: `Tx` = current data bit.
  - STOP: `Tx`=1.
- All state transitions and bit advances occur only on cycles with `TickTack`=1. Without a tick, the FSM holds state.
- IDLE → START: tick and FIFO non-empty. The head byte is popped into the shift register.
- START → DATA: on tick. Bit index = 0.
- DATA: on each tick, advance the bit index. After bit DATA_BITS-1 has been held for one period, go to STOP.
- STOP: on tick, the stop-bit counter advances. After STOP_BITS periods:
  - FIFO non-empty: pop and go to START (back-to-back frames, no idle gap).
  - FIFO empty: go to IDLE.
- Each bit is held for exactly one tick interval.
- Full: `Data_Ready`=0. A push attempted while full is ignored and the FIFO is unchanged. This holds even if a pop happens in the same cycle; `Data_Ready` reflects only the registered count.
- Empty with a tick in IDLE: stay in IDLE.
- Simultaneous push and pop when not full: both take effect and `Fifo_Count` is unchanged.
- FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. The count saturates logically, because a push is never accepted when full.
- `Reset_n` low at any time, including mid-frame:
  - FSM → IDLE, `Tx`=1.
  - FIFO emptied, pointers = 0.
  - `Busy`=0, `Data_Ready`=1.
  - The partial frame is abandoned. No completion is attempted after reset releases.

## Timing
- Tick-to-line latency: `Tx` changes on the `Clk` edge after the cycle in which `TickTack`=1.
- Frame length: (1 + DATA_BITS + STOP_BITS) tick intervals, which is 10 for 8N1.
- Start latency: a byte pushed at cycle k into an idle, empty block goes out at the first tick at cycle ≥ k+1. The `Tx` falling edge follows one cycle later.
- `Busy` rises in the same cycle `Tx` falls. It falls in the same cycle the FSM returns to IDLE.
- `Fifo_Count` and `Data_Ready` update one cycle after the push or pop edge.

## Structure
- Shared header (`xbee_defs.vh`): FSM state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), default DATA_BITS/STOP_BITS, and the baud constant shared with the tick generator.
- Sub-module `xbee_tx_fifo`:
  - Synchronous-write register-array FIFO with the same `Clk` and `Reset_n`.
  - Ports: push/pop, `full`/`empty`, count.
- The top contains the FSM, bit index counter, stop counter and shift register.

## Test plan
- Reset: hold `Reset_n`=0 → `Tx`=1, `Busy`=0, `Data_Ready`=1, `Fifo_Count`=0. Drive ticks with the FIFO empty → `Tx` stays 1.
- Single byte: push 0x55, tick every 10417 clocks → `Tx` sequence per tick 0,1,0,1,0,1,0,1,0,1. Then idle high; `Busy` high for exactly 10 tick intervals.
- Back-to-back: push 0xA3 then 0x0F → two contiguous frames (0,1,1,0,0,0,1,0,1,1 then 0,1,1,1,1,0,0,0,0,1) with no idle bit between.
- Full FIFO: push 5 bytes (0x01..0x05) without ticks:
  - `Data_Ready` drops after the 4th byte.
  - The 5th byte is dropped.
  - `Fifo_Count`=4.
  - After ticks, exactly 0x01..0x04 are transmitted.
- Simultaneous push/pop: push on the same cycle as a pop with count=2 → count stays 2 and byte order is preserved.
- Mid-frame reset: assert `Reset_n`=0 during DATA bit 3 of 0xFF with 2 bytes queued:
  - `Tx`=1 immediately (asynchronous reset).
  - `Fifo_Count`=0.
  - After release and further ticks, no frame is sent.

Source files
------------

// File: rtl/xbee_uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// xbee_uart_tx_pkg
//
// Definitions shared by the XBee UART transmit path and the baud tick
// generator that feeds it:
//   - tx_state_e   : transmit FSM state encoding
//   - Def*         : default frame format and buffer depth
//   - ClkFreqHz,
//     BaudRate,
//     BaudDiv      : clock / baud constants; BaudDiv is the tick generator's
//                    rounded clocks-per-bit figure (10417 at 100 MHz, 9600 bps)
//   - frame_ticks(): number of bit periods in one frame
// ----------------------------------------------------------------------------
package xbee_uart_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned DefDataBits  = 8;
    localparam int unsigned DefStopBits  = 1;
    localparam int unsigned DefFifoDepth = 4;

    localparam int unsigned ClkFreqHz = 100_000_000;
    localparam int unsigned BaudRate  = 9600;
    localparam int unsigned BaudDiv   = (ClkFreqHz + BaudRate / 2) / BaudRate;

    // Start bit + data bits + stop bits.
    function automatic int unsigned frame_ticks(input int unsigned data_bits,
                                                input int unsigned stop_bits);
        return 1 + data_bits + stop_bits;
    endfunction

endpackage

// File: rtl/xbee_tx_fifo.sv
// ----------------------------------------------------------------------------
// xbee_tx_fifo
//
// Small register-array FIFO buffering bytes ahead of the UART serialiser.
// Writes are synchronous; the head entry is presented combinationally on
// rdata_o so the FSM can load it in the same cycle it pops.
//
// Ports:
//   Clk      : system clock
//   Reset_n  : asynchronous active-low reset, empties the FIFO
//   push_i   : write wdata_i (ignored while full)
//   wdata_i  : data to write
//   pop_i    : discard the head entry (ignored while empty)
//   rdata_o  : head entry
//   full_o   : Depth entries held
//   empty_o  : no entries held
//   count_o  : number of entries held
// ----------------------------------------------------------------------------
module xbee_tx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come only from the registered count, so a push is refused
    // while full even if a pop frees a slot on the same edge.
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/xbee_uart_tx.sv
// ----------------------------------------------------------------------------
// xbee_uart_tx
//
// UART transmitter for the XBee link. Bytes arrive over a valid/ready
// handshake, are buffered in xbee_tx_fifo, and are sent as frames of
// start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits.
// Bit timing comes entirely from the external TickTack pulse; the FSM only
// moves on ticks.
//
// Ports:
//   Clk        : system clock (100 MHz)
//   Reset_n    : asynchronous active-low reset; abandons any frame in flight
//   TickTack   : one-cycle pulse per bit period
//   Data_In    : byte to send
//   Data_Valid : Data_In valid this cycle
//   Data_Ready : FIFO not full
//   Tx         : registered serial line, idle high
//   Busy       : a frame is on the line
//   Fifo_Count : bytes buffered
// ----------------------------------------------------------------------------
module xbee_uart_tx
    import xbee_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DefDataBits,
    parameter int unsigned STOP_BITS  = DefStopBits,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          TickTack,
    input  logic [DATA_BITS-1:0]          Data_In,
    input  logic                          Data_Valid,
    output logic                          Data_Ready,
    output logic                          Tx,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

    localparam int unsigned     IdxW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);
    localparam logic            StopLast = 1'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    xbee_tx_fifo #(
        .Width (DATA_BITS),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push_i  (Data_Valid),
        .wdata_i (Data_In),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (Fifo_Count)
    );

    assign Data_Ready = !fifo_full;
    assign Tx         = tx_q;
    assign Busy       = (state_q != StIdle);

    // Next-state logic. tx_d is derived from the state being entered, so the
    // line changes on the same edge that samples the tick and Busy tracks Tx.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        if (TickTack) begin
            unique case (state_q)
                StIdle: begin
                    tx_d = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        state_d  = StStart;
                        tx_d     = 1'b0;
                    end
                end

                StStart: begin
                    state_d   = StData;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end

                StData: begin
                    if (bit_idx_q == LastIdx) begin
                        state_d    = StStop;
                        stop_cnt_d = 1'b0;
                        tx_d       = 1'b1;
                    end else begin
                        // Shift so the next bit to send is always at bit 0.
                        bit_idx_d = bit_idx_q + IdxW'(1);
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_d[0];
                    end
                end

                StStop: begin
                    tx_d = 1'b1;
                    if (stop_cnt_q == StopLast) begin
                        if (!fifo_empty) begin
                            // Back-to-back frame: next start bit follows directly.
                            fifo_pop = 1'b1;
                            shreg_d  = fifo_rdata;
                            state_d  = StStart;
                            tx_d     = 1'b0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= StIdle;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

endmodule
